// File: rtl/i2s_adc_receiver_if.sv
// rtl/i2s_adc_receiver_if.sv - stereo PCM pair stream between the I2S receiver and the microphone stage
interface i2s_adc_receiver_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] left_data;
    logic [DATA_W-1:0] right_data;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output left_data,
        output right_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_adc_receiver.sv
// rtl/i2s_adc_receiver.sv - I2S ADC deserialiser with stereo pair handshake and peak level bar
module i2s_adc_receiver #(
    parameter int DATA_W     = 16,
    parameter int LED_N      = 18,
    parameter int STEP       = 1820,
    parameter int DECAY_LOG2 = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  aud_bclk,
    input  logic                  aud_adclrck,
    input  logic                  aud_adcdat,
    input  logic                  enable,
    input  logic                  clear_ovf,
    output logic                  overflow,
    output logic [LED_N-1:0]      level,
    i2s_adc_receiver_if.master    pcm
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

    state_t state, state_next;

    // [0],[1] are the synchroniser, [2] is the history flop used for edge detection
    logic [2:0] bclk_q, lr_q, dat_q;

    logic bclk_rise, lr_edge, lr_now, dat_bit;

    logic [DATA_W-1:0] shreg, left_hold, word_next;
    logic [CNT_W-1:0]  cnt;
    logic              chan;
    logic              armed, bad;

    logic word_done, start, abort, emit;

    logic [DATA_W-2:0]     peak, mag_l, mag_r, peak_max;
    logic [DECAY_LOG2-1:0] decay_cnt;
    logic                  decay_tick;
    logic [LED_N-1:0]      level_next;

    // Magnitude with the most-negative code clipped to full positive scale
    function automatic logic [DATA_W-2:0] mag_of(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] n;
        n = ~s + 1'b1;
        if (!s[DATA_W-1])
            return s[DATA_W-2:0];
        else if (n[DATA_W-1])
            return '1;
        else
            return n[DATA_W-2:0];
    endfunction

    // Bring the codec pins into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_q <= '0;
            lr_q   <= '0;
            dat_q  <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], aud_bclk};
            lr_q   <= {lr_q[1:0], aud_adclrck};
            dat_q  <= {dat_q[1:0], aud_adcdat};
        end
    end

    // Data comes from the history stage so it was sampled just before the BCLK rise reached the detector
    assign bclk_rise = bclk_q[1] & ~bclk_q[2];
    assign lr_edge   = lr_q[1] ^ lr_q[2];
    assign lr_now    = lr_q[1];
    assign dat_bit   = dat_q[2];
    assign word_next = {shreg[DATA_W-2:0], dat_bit};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state and word boundary events
    always_comb begin
        state_next = state;
        word_done  = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (lr_edge) begin
                        state_next = SKIP;
                        start      = 1'b1;
                    end
                end
                SKIP: begin
                    if (lr_edge) begin
                        start = 1'b1;
                        abort = 1'b1;
                    end else if (bclk_rise) begin
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (lr_edge) begin
                        state_next = SKIP;
                        start      = 1'b1;
                        abort      = 1'b1;
                    end else if (bclk_rise && cnt == LAST_BIT) begin
                        state_next = HOLD;
                        word_done  = 1'b1;
                    end
                end
                HOLD: begin
                    if (lr_edge) begin
                        state_next = SKIP;
                        start      = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign emit = word_done & chan & armed & ~bad;

    // Shift register, bit counter, channel and frame validity flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            left_hold <= '0;
            cnt       <= '0;
            chan      <= 1'b0;
            armed     <= 1'b0;
            bad       <= 1'b0;
        end else if (!enable) begin
            cnt   <= '0;
            armed <= 1'b0;
            bad   <= 1'b0;
        end else if (start) begin
            chan <= lr_now;
            cnt  <= '0;
            if (!lr_now) begin
                armed <= 1'b0;
                bad   <= 1'b0;
            end else if (abort) begin
                bad <= 1'b1;
            end
        end else if (state == SHIFT && bclk_rise) begin
            shreg <= word_next;
            cnt   <= cnt + 1'b1;
            if (word_done && !chan) begin
                left_hold <= word_next;
                armed     <= 1'b1;
            end
        end
    end

    // Output pair register and valid/ready handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcm.left_data    <= '0;
            pcm.right_data   <= '0;
            pcm.sample_valid <= 1'b0;
        end else if (emit && (!pcm.sample_valid || pcm.sample_ready)) begin
            pcm.left_data    <= left_hold;
            pcm.right_data   <= word_next;
            pcm.sample_valid <= 1'b1;
        end else if (pcm.sample_valid && pcm.sample_ready) begin
            pcm.sample_valid <= 1'b0;
        end
    end

    // Sticky overflow when a finished pair finds the output still occupied
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (emit && pcm.sample_valid && !pcm.sample_ready)
            overflow <= 1'b1;
        else if (clear_ovf)
            overflow <= 1'b0;
    end

    assign mag_l = mag_of(left_hold);
    assign mag_r = mag_of(word_next);

    // Largest of the held peak and the two new magnitudes
    always_comb begin
        peak_max = peak;
        if (mag_l > peak_max)
            peak_max = mag_l;
        if (mag_r > peak_max)
            peak_max = mag_r;
    end

    // Free-running decay timebase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            decay_cnt <= '0;
        else
            decay_cnt <= decay_cnt + 1'b1;
    end

    assign decay_tick = &decay_cnt;

    // Peak hold with exponential decay; a new pair takes priority over decay
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            peak <= '0;
        else if (emit)
            peak <= peak_max;
        else if (decay_tick)
            peak <= peak - (peak >> 4);
    end

    // Thermometer thresholds at multiples of STEP
    always_comb begin
        level_next = '0;
        for (int i = 0; i < LED_N; i++)
            level_next[i] = (int'(peak) >= (i + 1) * STEP);
    end

    // Register the bar one cycle behind the peak
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            level <= '0;
        else
            level <= level_next;
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb/tb_i2s_adc_receiver.sv - randomized self-checking bench for i2s_adc_receiver
module tb_i2s_adc_receiver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        aud_bclk, aud_adclrck, aud_adcdat;
    logic        enable, clear_ovf;
    logic        overflow, overflow_b;
    logic [17:0] level, level_b;

    i2s_adc_receiver_if #(.DATA_W(16)) pcm ();
    i2s_adc_receiver_if #(.DATA_W(16)) pcm_b ();

    assign pcm_b.sample_ready = 1'b1;

    always #10 clk = ~clk;

    i2s_adc_receiver #(.DATA_W(16), .LED_N(18), .STEP(1820), .DECAY_LOG2(20)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .aud_bclk    (aud_bclk),
        .aud_adclrck (aud_adclrck),
        .aud_adcdat  (aud_adcdat),
        .enable      (enable),
        .clear_ovf   (clear_ovf),
        .overflow    (overflow),
        .level       (level),
        .pcm         (pcm)
    );

    i2s_adc_receiver #(.DATA_W(16), .LED_N(18), .STEP(1820), .DECAY_LOG2(4)) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .aud_bclk    (aud_bclk),
        .aud_adclrck (aud_adclrck),
        .aud_adcdat  (aud_adcdat),
        .enable      (enable),
        .clear_ovf   (1'b0),
        .overflow    (overflow_b),
        .level       (level_b),
        .pcm         (pcm_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int valid_cycles = 0;
    int peak_m = 0;

    logic [15:0] obs_l[$], obs_r[$];
    logic [15:0] exp_l[$], exp_r[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mag_m(input logic [15:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic logic [17:0] bar_m(input int p);
        logic [17:0] b;
        for (int i = 0; i < 18; i++)
            b[i] = (p >= (i + 1) * 1820);
        return b;
    endfunction

    // Record every accepted pair
    always @(negedge clk) begin
        if (pcm.sample_valid) valid_cycles++;
        if (pcm.sample_valid && pcm.sample_ready) begin
            obs_l.push_back(pcm.left_data);
            obs_r.push_back(pcm.right_data);
        end
    end

    task automatic bit_cyc(input logic lr, input logic d);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_adcdat  = d;
        repeat (8) @(posedge clk);
        aud_bclk = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    // Slot 0 is the one-bit delay, slots 1..nbits carry the word MSB first
    task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits, input int len);
        logic d;
        for (int k = 0; k < len; k++) begin
            if (k >= 1 && k <= nbits) d = w[16 - k];
            else d = 1'($urandom);
            bit_cyc(lr, d);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits);
        send_slot(1'b0, l, lbits, (lbits < 16) ? lbits + 1 : 32);
        send_slot(1'b1, r, 16, 32);
    endtask

    task automatic model_pair(input logic [15:0] l, input logic [15:0] r);
        exp_l.push_back(l);
        exp_r.push_back(r);
        if (mag_m(l) > peak_m) peak_m = mag_m(l);
        if (mag_m(r) > peak_m) peak_m = mag_m(r);
    endtask

    task automatic check_pairs(input string tag);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_count"}, obs_l.size(), exp_l.size());
        while (obs_l.size() > 0 && exp_l.size() > 0) begin
            check({tag, "_left"}, obs_l.pop_front(), exp_l.pop_front());
            check({tag, "_right"}, obs_r.pop_front(), exp_r.pop_front());
        end
        obs_l.delete(); obs_r.delete();
        exp_l.delete(); exp_r.delete();
        check({tag, "_level"}, level, bar_m(peak_m));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        peak_m = 0;
        obs_l.delete(); obs_r.delete();
        exp_l.delete(); exp_r.delete();
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int vc0, t, viol;
        logic [17:0] prev;
        logic [15:0] l, r;
        int nb;
        logic saw_set;

        reset_n = 1'b0;
        aud_bclk = 1'b1; aud_adclrck = 1'b1; aud_adcdat = 1'b0;
        enable = 1'b1; clear_ovf = 1'b0;
        pcm.sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", pcm.sample_valid, 0);
        check("rst_left", pcm.left_data, 0);
        check("rst_right", pcm.right_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_level", level, 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // Nominal frame
        vc0 = valid_cycles;
        send_frame(16'h8001, 16'h7FFE, 16);
        model_pair(16'h8001, 16'h7FFE);
        check_pairs("nominal");
        check("nominal_valid_cycles", valid_cycles - vc0, 1);
        check("nominal_ovf", overflow, 0);

        // Random frames, some with a truncated left word
        for (int i = 0; i < 10; i++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 14) : 16;
            send_frame(l, r, nb);
            if (nb == 16) model_pair(l, r);
        end
        check_pairs("random");

        // Short word then a good frame
        send_frame(16'h1111, 16'h2222, 10);
        send_frame(16'h0ABC, 16'hF123, 16);
        model_pair(16'h0ABC, 16'hF123);
        check_pairs("short");

        // Backpressure: A held, B dropped, C's set beats a simultaneous clear
        pcm.sample_ready = 1'b0;
        send_frame(16'h1234, 16'h0F00, 16);
        @(negedge clk);
        check("bp_a_valid", pcm.sample_valid, 1);
        send_frame(16'h0010, 16'h0020, 16);
        @(negedge clk);
        check("bp_ovf_set", overflow, 1);
        check("bp_a_left", pcm.left_data, 16'h1234);
        check("bp_a_right", pcm.right_data, 16'h0F00);
        clear_ovf = 1'b1;
        saw_set = 1'b0;
        fork
            send_frame(16'h0011, 16'h0021, 16);
            begin
                t = 0;
                while (overflow !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
                while (overflow !== 1'b1 && t < 4000) begin @(negedge clk); t++; end
                saw_set = overflow;
                clear_ovf = 1'b0;
            end
        join
        clear_ovf = 1'b0;
        check("bp_set_wins_seen", saw_set, 1);
        @(negedge clk);
        check("bp_ovf_after_c", overflow, 1);
        check("bp_a_stable", pcm.left_data, 16'h1234);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        @(negedge clk);
        check("bp_ovf_cleared", overflow, 0);
        model_pair(16'h1234, 16'h0F00);
        if (mag_m(16'h0011) > peak_m) peak_m = mag_m(16'h0011);
        pcm.sample_ready = 1'b1;
        check_pairs("bp");
        check("bp_valid_drop", pcm.sample_valid, 0);

        // Reset during left bit 7 with a pair held
        pcm.sample_ready = 1'b0;
        send_frame(16'h4000, 16'h0100, 16);
        @(negedge clk);
        check("rmw_pre_valid", pcm.sample_valid, 1);
        send_slot(1'b0, 16'h5555, 16, 8);
        reset_n = 1'b0;
        #2;
        check("rmw_valid", pcm.sample_valid, 0);
        check("rmw_left", pcm.left_data, 0);
        check("rmw_right", pcm.right_data, 0);
        check("rmw_level", level, 0);
        pcm.sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        peak_m = 0;
        obs_l.delete(); obs_r.delete();
        exp_l.delete(); exp_r.delete();
        send_slot(1'b1, 16'h0000, 16, 32);
        send_frame(16'hC3A5, 16'h3C5A, 16);
        model_pair(16'hC3A5, 16'h3C5A);
        check_pairs("rmw_after");

        // Enable drop during the right word
        send_slot(1'b0, 16'h7777, 16, 32);
        for (int k = 0; k < 32; k++) begin
            if (k == 8) enable = 1'b0;
            bit_cyc(1'b1, 1'($urandom));
        end
        enable = 1'b1;
        send_frame(16'h0102, 16'hFEFD, 16);
        model_pair(16'h0102, 16'hFEFD);
        check_pairs("en_drop");

        // Meter thresholds
        do_reset();
        send_frame(16'd3640, 16'd0, 16);
        model_pair(16'd3640, 16'd0);
        check_pairs("step_3640");
        check("step_3640_bar", level, 18'h00003);
        do_reset();
        send_frame(16'd3639, 16'd0, 16);
        model_pair(16'd3639, 16'd0);
        check_pairs("step_3639");
        check("step_3639_bar", level, 18'h00001);

        // Saturation on both meters and decay on the fast-decay instance
        do_reset();
        fork
            send_frame(16'h8000, 16'h0000, 16);
            begin
                t = 0;
                while (pcm_b.sample_valid !== 1'b1 && t < 20000) begin @(negedge clk); t++; end
                check("dec_valid_seen", (t < 20000), 1);
                @(negedge clk);
                check("dec_level_sat", level_b, 18'h3FFFF);
                prev = level_b;
                viol = 0;
                t = 0;
                while (level_b != 18'h0 && t < 5000) begin
                    @(negedge clk);
                    if (level_b > prev) viol++;
                    prev = level_b;
                    t++;
                end
                check("dec_monotonic", viol, 0);
                check("dec_reaches_zero", level_b, 0);
            end
        join
        model_pair(16'h8000, 16'h0000);
        check_pairs("sat");
        check("sat_bar", level, 18'h3FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
